// File: rtl/mac_accum_ctrl_pkg.sv
// Shared types and constants for the MAC issue/retire controller.
package mac_accum_ctrl_pkg;

    localparam int MAC_LAT    = 11;
    localparam int C_OFS      = 4;
    localparam int META_IDX_W = 4;

    localparam logic [63:0] FP64_ZERO = 64'h0;

    typedef struct packed {
        logic                  v;
        logic [META_IDX_W-1:0] idx;
        logic                  first;
        logic                  last;
    } mac_meta_t;

endpackage

// File: rtl/mac_meta_pipe.sv
// Delay line of per-term metadata; stage k holds the term issued k cycles ago.
module mac_meta_pipe
    import mac_accum_ctrl_pkg::*;
#(
    parameter int LAT  = MAC_LAT,
    parameter int COFS = C_OFS
) (
    input  logic      clk,
    input  logic      rst_n,
    input  mac_meta_t meta_in,
    output mac_meta_t tap_1,
    output mac_meta_t tap_c,
    output mac_meta_t tap_lat
);

    mac_meta_t pipe_q [0:LAT];
    mac_meta_t pipe_d [0:LAT];

    always_comb begin
        pipe_d[0] = meta_in;
        for (int k = 1; k <= LAT; k++) begin
            pipe_d[k] = pipe_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= LAT; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign tap_1   = pipe_q[1];
    assign tap_c   = pipe_q[COFS-1];
    assign tap_lat = pipe_q[LAT];

endmodule

// File: rtl/mac_accum_ctrl.sv
// Issues operand pairs to the MAC, supplies C from the accumulator file and
// retires results back into it, with a per-entry busy scoreboard.
module mac_accum_ctrl
    import mac_accum_ctrl_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int IDX_W   = $clog2(DEPTH),
    parameter int MAC_LAT = mac_accum_ctrl_pkg::MAC_LAT,
    parameter int C_OFS   = mac_accum_ctrl_pkg::C_OFS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_a,
    input  logic [63:0]      in_b,
    input  logic [IDX_W-1:0] in_idx,
    input  logic             in_first,
    input  logic             in_last,
    output logic             mac_valid_in,
    output logic [63:0]      mac_ta,
    output logic [63:0]      mac_tb,
    output logic [63:0]      mac_c,
    input  logic [63:0]      mac_res,
    input  logic             mac_load_valid,
    input  logic             mac_store_valid,
    input  logic             mac_error,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic [63:0]      out_data,
    output logic             out_error,
    input  logic             err_clr,
    output logic             err_sticky,
    output logic             sync_err,
    output logic             busy_any
);

    localparam int CNT_W = $clog2(MAC_LAT + 2);

    logic [DEPTH-1:0]        busy_q, busy_d;
    logic [DEPTH-1:0][63:0]  acc_q, acc_d;
    logic [63:0]             ta_q, ta_d, tb_q, tb_d, c_q, c_d;
    logic                    mac_valid_q, mac_valid_d;
    logic                    out_valid_q, out_valid_d;
    logic [IDX_W-1:0]        out_idx_q, out_idx_d;
    logic [63:0]             out_data_q, out_data_d;
    logic                    out_error_q, out_error_d;
    logic                    err_sticky_q, err_sticky_d;
    logic                    sync_err_q, sync_err_d;
    logic [CNT_W-1:0]        mask_cnt_q, mask_cnt_d;

    mac_meta_t               meta_in, tap_1, tap_c, tap_lat;
    logic                    accept, masked, load_mis, store_mis, retire;
    logic [IDX_W-1:0]        c_idx, r_idx;

    mac_meta_pipe #(.LAT(MAC_LAT), .COFS(C_OFS)) u_meta_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .meta_in (meta_in),
        .tap_1   (tap_1),
        .tap_c   (tap_c),
        .tap_lat (tap_lat)
    );

    assign in_ready = !busy_q[in_idx];
    assign accept   = in_valid & in_ready;
    // The MAC itself is never reset, so its handshakes are ignored until any
    // term issued before reset has drained out.
    assign masked    = mask_cnt_q != '0;
    assign load_mis  = !masked & (mac_load_valid != tap_1.v);
    assign store_mis = !masked & (mac_store_valid != tap_lat.v);
    assign retire    = !masked & mac_store_valid & tap_lat.v;
    assign c_idx     = tap_c.idx[IDX_W-1:0];
    assign r_idx     = tap_lat.idx[IDX_W-1:0];

    always_comb begin
        meta_in       = '0;
        meta_in.v     = accept;
        meta_in.idx   = META_IDX_W'(in_idx);
        meta_in.first = in_first;
        meta_in.last  = in_last;
    end

    always_comb begin
        busy_d       = busy_q;
        acc_d        = acc_q;
        ta_d         = ta_q;
        tb_d         = tb_q;
        c_d          = c_q;
        mac_valid_d  = accept;
        out_valid_d  = 1'b0;
        out_idx_d    = out_idx_q;
        out_data_d   = out_data_q;
        out_error_d  = out_error_q;
        err_sticky_d = err_sticky_q;
        sync_err_d   = sync_err_q;
        mask_cnt_d   = masked ? mask_cnt_q - 1'b1 : mask_cnt_q;

        if (accept) begin
            ta_d           = in_a;
            tb_d           = in_b;
            busy_d[in_idx] = 1'b1;
        end

        // Busy guarantees no retire targets c_idx, so acc_q is final here.
        if (tap_c.v) begin
            c_d = tap_c.first ? FP64_ZERO : acc_q[c_idx];
        end

        if (retire) begin
            acc_d[r_idx]  = mac_res;
            busy_d[r_idx] = 1'b0;
            if (tap_lat.last) begin
                out_valid_d = 1'b1;
                out_idx_d   = r_idx;
                out_data_d  = mac_res;
                out_error_d = mac_error;
            end
        end

        if (err_clr) begin
            err_sticky_d = 1'b0;
            sync_err_d   = 1'b0;
        end
        if (retire && mac_error) err_sticky_d = 1'b1;
        if (load_mis || store_mis) sync_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q       <= '0;
            acc_q        <= '0;
            ta_q         <= FP64_ZERO;
            tb_q         <= FP64_ZERO;
            c_q          <= FP64_ZERO;
            mac_valid_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_idx_q    <= '0;
            out_data_q   <= FP64_ZERO;
            out_error_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            sync_err_q   <= 1'b0;
            mask_cnt_q   <= CNT_W'(MAC_LAT + 1);
        end else begin
            busy_q       <= busy_d;
            acc_q        <= acc_d;
            ta_q         <= ta_d;
            tb_q         <= tb_d;
            c_q          <= c_d;
            mac_valid_q  <= mac_valid_d;
            out_valid_q  <= out_valid_d;
            out_idx_q    <= out_idx_d;
            out_data_q   <= out_data_d;
            out_error_q  <= out_error_d;
            err_sticky_q <= err_sticky_d;
            sync_err_q   <= sync_err_d;
            mask_cnt_q   <= mask_cnt_d;
        end
    end

    assign mac_valid_in = mac_valid_q;
    assign mac_ta       = ta_q;
    assign mac_tb       = tb_q;
    assign mac_c        = c_q;
    assign out_valid    = out_valid_q;
    assign out_idx      = out_idx_q;
    assign out_data     = out_data_q;
    assign out_error    = out_error_q;
    assign err_sticky   = err_sticky_q;
    assign sync_err     = sync_err_q;
    assign busy_any     = |busy_q;

endmodule

// File: tb/tb_mac_accum_ctrl.sv
// Bench for mac_accum_ctrl: behavioural MAC stand-in plus an arithmetic
// accumulator reference model.
module tb_mac_accum_ctrl;

    localparam int L  = 11;
    localparam int CO = 4;
    localparam logic [63:0] ONE   = 64'h3FF0000000000000;
    localparam logic [63:0] TWO   = 64'h4000000000000000;
    localparam logic [63:0] THREE = 64'h4008000000000000;
    localparam logic [63:0] ONE_P5 = 64'h3FF8000000000000;
    localparam logic [63:0] BIG   = 64'h7E37E43C8800759C;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_first, in_last;
    logic [63:0] in_a, in_b;
    logic [3:0]  in_idx;
    logic        mac_valid_in;
    logic [63:0] mac_ta, mac_tb, mac_c, mac_res;
    logic        mac_load_valid, mac_store_valid, mac_error;
    logic        out_valid, out_error;
    logic [3:0]  out_idx;
    logic [63:0] out_data;
    logic        err_clr, err_sticky, sync_err, busy_any;
    logic        force_sv = 1'b0;

    always #5 clk = ~clk;

    mac_accum_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_idx(in_idx), .in_first(in_first), .in_last(in_last),
        .mac_valid_in(mac_valid_in), .mac_ta(mac_ta), .mac_tb(mac_tb), .mac_c(mac_c),
        .mac_res(mac_res), .mac_load_valid(mac_load_valid),
        .mac_store_valid(mac_store_valid), .mac_error(mac_error),
        .out_valid(out_valid), .out_idx(out_idx), .out_data(out_data),
        .out_error(out_error), .err_clr(err_clr), .err_sticky(err_sticky),
        .sync_err(sync_err), .busy_any(busy_any)
    );

    // MAC stand-in (no reset): entry at index k is k cycles past its valid_in cycle.
    bit        mv [1:L];
    bit [63:0] ma [1:L];
    bit [63:0] mb [1:L];
    bit [63:0] mr [1:L];

    always @(posedge clk) begin
        for (int k = L; k >= 2; k--) begin
            mv[k] <= mv[k-1];
            ma[k] <= ma[k-1];
            mb[k] <= mb[k-1];
            if (k == CO + 1)
                mr[k] <= $realtobits($bitstoreal(ma[k-1]) * $bitstoreal(mb[k-1]) + $bitstoreal(mac_c));
            else
                mr[k] <= mr[k-1];
        end
        mv[1] <= mac_valid_in;
        ma[1] <= mac_ta;
        mb[1] <= mac_tb;
        mr[1] <= 64'h0;
    end

    assign mac_load_valid  = mv[1];
    assign mac_store_valid = mv[L] | force_sv;
    assign mac_res         = mr[L];
    assign mac_error       = mv[L] && (mr[L][62:52] == 11'h7FF);

    typedef struct {
        int          cyc;
        logic [3:0]  idx;
        logic [63:0] data;
        logic        err;
    } ev_t;

    logic [63:0] ref_acc [16];
    ev_t exp_q[$];
    ev_t obs_q[$];
    int  cyc = 0;
    int  asserts = 0;
    int  fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (rst_n && out_valid) obs_q.push_back('{cyc, out_idx, out_data, out_error});

    // Offer one pair (called at a negedge); m returns the accept cycle.
    task automatic issue(input logic [3:0] idx, input logic [63:0] a, input logic [63:0] b,
                         input logic first, input logic last, output int stalls, output int m);
        real r;
        ev_t e;
        stalls = 0;
        m = -1;
        in_valid = 1'b1; in_idx = idx; in_a = a; in_b = b; in_first = first; in_last = last;
        #1;
        while (!in_ready && stalls < 100) begin
            @(negedge clk); #1; stalls++;
        end
        asserts++;
        if (!in_ready) begin
            fails++;
            $display("FAIL issue_timeout idx=%0d in_ready=%b required 1", idx, in_ready);
        end else begin
            m = cyc;
            r = $bitstoreal(a) * $bitstoreal(b) + (first ? 0.0 : $bitstoreal(ref_acc[idx]));
            ref_acc[idx] = $realtobits(r);
            if (last) begin
                e.cyc = m + L + 2; e.idx = idx; e.data = ref_acc[idx];
                e.err = (ref_acc[idx][62:52] == 11'h7FF);
                exp_q.push_back(e);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] got;
        in_idx = 4'd0;
        #1;
        got = {in_ready, mac_valid_in, out_valid, out_error, err_sticky, sync_err, busy_any, 1'b0};
        asserts++;
        if (got !== 8'b1000_0000) begin
            fails++; $display("FAIL reset_flags got %b required 10000000", got);
        end
        asserts++;
        if ({mac_ta, mac_tb, mac_c, out_data} !== 256'h0 || out_idx !== 4'd0) begin
            fails++; $display("FAIL reset_data got ta=%h tb=%h c=%h out=%h idx=%0d required 0",
                              mac_ta, mac_tb, mac_c, out_data, out_idx);
        end
        repeat (14) @(negedge clk);
    endtask

    task automatic test_single();
        int st, m;
        ev_t o;
        issue(4'd3, ONE_P5, TWO, 1'b1, 1'b1, st, m);
        asserts++;
        if (mac_valid_in !== 1'b1 || mac_ta !== ONE_P5 || mac_tb !== TWO || busy_any !== 1'b1 || in_ready !== 1'b0) begin
            fails++; $display("FAIL single_issue got v=%b ta=%h tb=%h busy=%b rdy=%b required 1 %h %h 1 0",
                              mac_valid_in, mac_ta, mac_tb, busy_any, in_ready, ONE_P5, TWO);
        end
        @(negedge clk);
        asserts++;
        if (mac_valid_in !== 1'b0) begin
            fails++; $display("FAIL single_valid_pulse got %b required 0", mac_valid_in);
        end
        repeat (14) @(negedge clk);
        asserts++;
        if (obs_q.size() != 1) begin
            fails++; $display("FAIL single_count got %0d required 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            asserts++;
            if (o.cyc !== m + 13 || o.idx !== 4'd3 || o.data !== THREE || o.err !== 1'b0) begin
                fails++; $display("FAIL single_out got cyc=%0d idx=%0d data=%h err=%b required %0d 3 %h 0",
                                  o.cyc, o.idx, o.data, o.err, m + 13, THREE);
            end
        end
        asserts++;
        if (busy_any !== 1'b0) begin
            fails++; $display("FAIL single_busy_clear got %b required 0", busy_any);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_accumulate();
        int st[3];
        int m;
        ev_t o;
        for (int i = 0; i < 3; i++) begin
            issue(4'd0, ONE, ONE, i == 0, i == 2, st[i], m);
            if (i > 0) begin
                asserts++;
                if (st[i] != 12) begin
                    fails++; $display("FAIL accum_stall term=%0d got %0d required 12", i, st[i]);
                end
            end
        end
        repeat (14) @(negedge clk);
        asserts++;
        if (obs_q.size() != 1) begin
            fails++; $display("FAIL accum_count got %0d required 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            asserts++;
            if (o.cyc !== m + 13 || o.idx !== 4'd0 || o.data !== THREE) begin
                fails++; $display("FAIL accum_out got cyc=%0d idx=%0d data=%h required %0d 0 %h",
                                  o.cyc, o.idx, o.data, m + 13, THREE);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_interleave();
        int st, m, m0;
        ev_t o;
        m0 = 0;
        for (int i = 0; i < 12; i++) begin
            issue(4'(i), ONE, TWO, 1'b1, 1'b1, st, m);
            if (i == 0) m0 = m;
            asserts++;
            if (st != 0) begin
                fails++; $display("FAIL interleave_stall idx=%0d got %0d required 0", i, st);
            end
        end
        repeat (14) @(negedge clk);
        asserts++;
        if (obs_q.size() != 12) begin
            fails++; $display("FAIL interleave_count got %0d required 12", obs_q.size());
        end
        for (int i = 0; i < 12 && obs_q.size() > 0; i++) begin
            o = obs_q.pop_front();
            asserts++;
            if (o.cyc !== m0 + 13 + i || o.idx !== 4'(i) || o.data !== TWO) begin
                fails++; $display("FAIL interleave_out got cyc=%0d idx=%0d data=%h required %0d %0d %h",
                                  o.cyc, o.idx, o.data, m0 + 13 + i, i, TWO);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_overflow();
        int st, m;
        ev_t o;
        issue(4'd9, BIG, BIG, 1'b1, 1'b1, st, m);
        repeat (14) @(negedge clk);
        asserts++;
        if (obs_q.size() != 1) begin
            fails++; $display("FAIL ovf_count got %0d required 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            asserts++;
            if (o.err !== 1'b1 || o.idx !== 4'd9 || o.data !== 64'h7FF0000000000000) begin
                fails++; $display("FAIL ovf_out got err=%b idx=%0d data=%h required 1 9 7ff0000000000000",
                                  o.err, o.idx, o.data);
            end
        end
        asserts++;
        if (err_sticky !== 1'b1) begin
            fails++; $display("FAIL ovf_sticky got %b required 1", err_sticky);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        asserts++;
        if (err_sticky !== 1'b0) begin
            fails++; $display("FAIL ovf_clr got %b required 0", err_sticky);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        int st, m;
        bit seen [16];
        logic [3:0] idx;
        ev_t o, e;
        for (int i = 0; i < 16; i++) seen[i] = 1'b0;
        for (int n = 0; n < 80; n++) begin
            idx = 4'($urandom_range(0, 15));
            issue(idx, $realtobits(real'($urandom_range(0, 8))), $realtobits(real'($urandom_range(0, 8))),
                  !seen[idx] || ($urandom_range(0, 3) == 0), $urandom_range(0, 2) == 0, st, m);
            seen[idx] = 1'b1;
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        repeat (16) @(negedge clk);
        asserts++;
        if (obs_q.size() != exp_q.size()) begin
            fails++; $display("FAIL random_count got %0d required %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            asserts++;
            if (o.cyc !== e.cyc || o.idx !== e.idx || o.data !== e.data || o.err !== e.err) begin
                fails++; $display("FAIL random_out got cyc=%0d idx=%0d data=%h err=%b required %0d %0d %h %b",
                                  o.cyc, o.idx, o.data, o.err, e.cyc, e.idx, e.data, e.err);
            end
        end
        asserts++;
        if (sync_err !== 1'b0 || err_sticky !== 1'b0) begin
            fails++; $display("FAIL random_flags got sync=%b sticky=%b required 0 0", sync_err, err_sticky);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_sync_fault();
        int st, m;
        ev_t o, e;
        force_sv = 1'b1;
        @(negedge clk);
        force_sv = 1'b0;
        asserts++;
        if (sync_err !== 1'b1 || busy_any !== 1'b0) begin
            fails++; $display("FAIL sync_set got sync=%b busy=%b required 1 0", sync_err, busy_any);
        end
        // A stray store must not have disturbed any entry.
        for (int i = 0; i < 16; i++) issue(4'(i), ONE, ONE, 1'b0, 1'b1, st, m);
        repeat (15) @(negedge clk);
        asserts++;
        if (obs_q.size() != exp_q.size()) begin
            fails++; $display("FAIL sync_count got %0d required %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            asserts++;
            if (o.idx !== e.idx || o.data !== e.data) begin
                fails++; $display("FAIL sync_acc got idx=%0d data=%h required %0d %h", o.idx, o.data, e.idx, e.data);
            end
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        asserts++;
        if (sync_err !== 1'b0 || err_sticky !== 1'b0) begin
            fails++; $display("FAIL sync_clr got sync=%b sticky=%b required 0 0", sync_err, err_sticky);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_midflight();
        int st, m;
        ev_t o, e;
        issue(4'd5, ONE, TWO, 1'b1, 1'b1, st, m);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        obs_q.delete(); exp_q.delete();
        for (int i = 0; i < 16; i++) ref_acc[i] = 64'h0;
        repeat (20) @(negedge clk);
        asserts++;
        if (obs_q.size() != 0 || sync_err !== 1'b0 || busy_any !== 1'b0) begin
            fails++; $display("FAIL rst_mid got outs=%0d sync=%b busy=%b required 0 0 0",
                              obs_q.size(), sync_err, busy_any);
        end
        for (int i = 0; i < 16; i++) issue(4'(i), ONE, ONE, 1'b0, 1'b1, st, m);
        repeat (15) @(negedge clk);
        asserts++;
        if (obs_q.size() != 16) begin
            fails++; $display("FAIL rst_acc_count got %0d required 16", obs_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            asserts++;
            if (o.cyc !== e.cyc || o.idx !== e.idx || o.data !== ONE) begin
                fails++; $display("FAIL rst_acc got cyc=%0d idx=%0d data=%h required %0d %0d %h",
                                  o.cyc, o.idx, o.data, e.cyc, e.idx, ONE);
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ref_acc[i] = 64'h0;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_idx = '0;
        in_first = 1'b0; in_last = 1'b0; err_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_single();
        test_accumulate();
        test_interleave();
        test_overflow();
        test_random();
        test_sync_fault();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
